// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, width-generic ALU with registered result and status flags.
// Optional iterative shift-add multiplier on opcode 10, enabled by defining ALU_PIPE_MUL_EN.
// Without the macro, opcode 10 is treated as an illegal op and Busy is tied low.
module alu_pipe #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned SHAMT_W = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUOp,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] ALUOut,
   output logic             Zero,
   output logic             Neg,
   output logic             Carry,
   output logic             Ovf,
   output logic             IllegalOp,
   output logic             Busy
);

   localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);

   logic             accept;
   logic             idle;
   logic             is_mul;
   logic             mul_done;
   logic [WIDTH-1:0] mul_res;

   logic [WIDTH-1:0]   res;
   logic               c_d;
   logic               v_d;
   logic               ill_d;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [SHAMT_W-1:0] sh;
   logic               big;

   // A new op may enter only when no multiply runs and the output slot is free or draining.
   assign InReady = RST_N && idle && (!OutValid || OutReady);
   assign accept  = InValid && InReady;

   assign sh   = B[SHAMT_W-1:0];
   assign big  = (B >= WidthVal);
   assign sum  = {1'b0, A} + {1'b0, B};
   // Top bit of the extended difference is the borrow; carry reports its inverse.
   assign diff = {1'b0, A} - {1'b0, B};

   // Single-cycle result and flags for the op currently presented.
   always_comb begin
      res   = '0;
      c_d   = 1'b0;
      v_d   = 1'b0;
      ill_d = 1'b0;
      case (ALUOp)
         4'd0: begin
            res = sum[WIDTH-1:0];
            c_d = sum[WIDTH];
            v_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         4'd1: begin
            res = diff[WIDTH-1:0];
            c_d = ~diff[WIDTH];
            v_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         4'd2: res = A & B;
         4'd3: res = A | B;
         4'd4: res = A ^ B;
         4'd5: res = big ? '0 : (A << sh);
         4'd6: res = big ? '0 : (A >> sh);
         4'd7: res = big ? {WIDTH{A[WIDTH-1]}} : $unsigned($signed(A) >>> sh);
         4'd8: res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         4'd9: res = {{(WIDTH-1){1'b0}}, (A < B)};
         default: ill_d = 1'b1;
      endcase
   end

`ifdef ALU_PIPE_MUL_EN
   typedef enum logic {StIdle, StMul} state_e;

   localparam logic [SHAMT_W:0] CntMax = (SHAMT_W+1)'(WIDTH);

   state_e             state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W:0]   cnt;

   assign idle     = (state == StIdle);
   assign is_mul   = (ALUOp == 4'd10);
   assign mul_done = (state == StMul) && (cnt == CntMax);
   assign mul_res  = acc;
   assign Busy     = (state == StMul);

   // Multiply FSM: WIDTH shift-add iterations, then one cycle to hand the product out.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= StIdle;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (accept && is_mul) begin
                  state  <= StMul;
                  mcand  <= A;
                  mplier <= B;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            StMul: begin
               if (cnt == CntMax) begin
                  state <= StIdle;
               end else begin
                  if (mplier[0]) acc <= acc + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + (SHAMT_W+1)'(1);
               end
            end
            default: state <= StIdle;
         endcase
      end
   end
`else
   assign idle     = 1'b1;
   assign is_mul   = 1'b0;
   assign mul_done = 1'b0;
   assign mul_res  = '0;
   assign Busy     = 1'b0;
`endif

   // Output register: load on accept or multiply completion, clear valid when consumed.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OutValid  <= 1'b0;
         ALUOut    <= '0;
         Zero      <= 1'b0;
         Neg       <= 1'b0;
         Carry     <= 1'b0;
         Ovf       <= 1'b0;
         IllegalOp <= 1'b0;
      end else if (accept && !is_mul) begin
         OutValid  <= 1'b1;
         ALUOut    <= res;
         Zero      <= (res == '0);
         Neg       <= res[WIDTH-1];
         Carry     <= c_d;
         Ovf       <= v_d;
         IllegalOp <= ill_d;
      end else if (accept) begin
         // Multiply launched; the previous result was consumed on this same edge.
         OutValid <= 1'b0;
      end else if (mul_done) begin
         OutValid  <= 1'b1;
         ALUOut    <= mul_res;
         Zero      <= (mul_res == '0);
         Neg       <= mul_res[WIDTH-1];
         Carry     <= 1'b0;
         Ovf       <= 1'b0;
         IllegalOp <= 1'b0;
      end else if (OutReady) begin
         OutValid <= 1'b0;
      end
   end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the 16-bit clocked ALU.
- Width is generic; the opcode space grows to 4 bits (adds SRA, SLT, SLTU, optional MUL).
- Status flags are registered with the result.
- Valid/ready on input and output lets the datapath stall cleanly; sits between operand fetch and writeback.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- SHAMT_W, 4, shift-amount field width taken from B; must equal clog2(WIDTH).

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- InValid  in  1  operand/opcode presented
- InReady  out  1  block can accept an operation this cycle
- A  in  WIDTH  operand A (shift source)
- B  in  WIDTH  operand B (shift amount for shifts)
- ALUOp  in  4  operation select
- OutValid  out  1  ALUOut/flags hold a completed result
- OutReady  in  1  consumer accepts result
- ALUOut  out  WIDTH  result
- Zero  out  1  ALUOut == 0
- Neg  out  1  ALUOut[WIDTH-1]
- Carry  out  1  ADD carry-out; SUB no-borrow (A >= B unsigned); else 0
- Ovf  out  1  signed overflow for ADD/SUB; else 0
- IllegalOp  out  1  result came from an undefined opcode
- Busy  out  1  multi-cycle operation in progress

Behaviour:
- Reset (async, RST_N=0): ALUOut=0; all flags 0; OutValid=0; Busy=0; FSM=IDLE; InReady=0 while asserted.
- Accept = InValid && InReady, sampled on CLK rise.
- InReady = (FSM==IDLE) && (!OutValid || OutReady); combinational.
- Single-cycle ops: result registered on the accepting edge. OutValid=1 from the next cycle. Latency 1.
- Back-to-back accepts sustain 1 op/cycle while OutReady=1.
- OutValid && !OutReady: ALUOut and flags hold stable; InReady=0; no new op accepted, no result lost.
- OutValid clears on the OutReady edge unless a new accept occurs in the same edge. In that case the new result overwrites and OutValid stays 1.
- Opcodes:
  - 0 ADD; 1 SUB (A-B); 2 AND; 3 OR; 4 XOR
  - 5 SLL (A<<sh); 6 SRL (A>>sh logical); 7 SRA (arithmetic)
  - 8 SLT signed (1/0); 9 SLTU unsigned (1/0); 10 MUL
  - 11-15 undefined
- Shift amount sh = B[SHAMT_W-1:0] when B < WIDTH.
- If B >= WIDTH (unsigned): SLL/SRL give 0; SRA gives all copies of A[WIDTH-1].
- ADD/SUB wrap modulo 2^WIDTH. Carry/Ovf are computed on the WIDTH+1-bit sum.
- Zero and Neg are valid for every op, derived from the registered result.
- Undefined op (or MUL when compiled out): ALUOut=0, Zero=1, IllegalOp=1, latency 1. IllegalOp is 0 for all legal ops.
- FSM: IDLE -> MUL on accepting op 10, else stays IDLE.
- MUL state:
  - WIDTH iterations of shift-add on internal multiplicand/multiplier/accumulator.
  - Busy=1, InReady=0 throughout.
  - MUL -> IDLE after iteration WIDTH; result (low WIDTH bits, unsigned product) is loaded into ALUOut with OutValid=1.
  - Latency WIDTH+1 cycles from accept to OutValid.
  - Flags for MUL: Zero/Neg from result; Carry=Ovf=0.
- Reset mid-operation: multiply aborted, partial product discarded; pending result dropped.
- Operands change while InReady=0: ignored.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: opcode 10 runs the iterative MUL FSM as above; Busy can assert.
- Undefined: no MUL state or datapath is synthesised; opcode 10 behaves as an illegal op (ALUOut=0, IllegalOp=1, latency 1); Busy is tied to 0.

Test Plan:
- WIDTH=16, A=2, B=1, OutReady=1, ops 0-6 back to back -> ALUOut 3,1,0,3,3,4,1, each valid one cycle after its accept; IllegalOp=0.
- ADD 0x7FFF+0x0001 -> 0x8000, Ovf=1, Neg=1, Carry=0. SUB 5-5 -> 0x0000, Zero=1, Carry=1. SLT 0xFFFF,0x0001 -> 1. SLTU same operands -> 0.
- Backpressure: OutReady=0, accept ADD 1+1 -> ALUOut=2 holds, InReady=0 for 5 cycles, second op not taken. Raise OutReady -> second op accepted same edge, its result follows next cycle.
- Shifts: SRA 0x8000 by 3 -> 0xF000. SRA 0x8000 by B=20 -> 0xFFFF. SLL 0x0001 by 16 -> 0x0000. Opcode 13 -> 0x0000, IllegalOp=1, Zero=1.
- ALU_PIPE_MUL_EN defined: MUL 300*7 -> 2100 with OutValid exactly 17 cycles after accept, Busy=1 and InReady=0 in between. MUL 0xFFFF*2 -> 0xFFFE. Macro undefined: opcode 10 -> 0, IllegalOp=1.
- Assert RST_N=0 mid-multiply (cycle 5) -> OutValid, Busy, ALUOut clear immediately without a clock. After release, ADD 2+1 is accepted and returns 3.
